// File: rtl/instr_pack.sv
// Shared encodings for param_reg_file: PC operation codes and fixed register roles.
package instr_pack;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_LJMP = 2'd2,
        PC_HOLD = 2'd3
    } pc_op_t;

    // Rotate pair lives at fixed low addresses; target and PC sit at the top of the file.
    localparam int unsigned R_M       = 4;
    localparam int unsigned R_N       = 5;
    localparam int unsigned R_TGT_OFS = 2;
    localparam int unsigned R_PC_OFS  = 1;

endpackage

// File: rtl/pair_rotator.sv
// Rotate engine for the {m,n} register pair: IDLE/SHIFT/DONE FSM, step counter and pair storage.
module pair_rotator
    import instr_pack::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SW   = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sh_start,
    input  logic             sh_left,
    input  logic [SW-1:0]    sh_amt,
    input  logic             wr_m,
    input  logic             wr_n,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] n,
    output logic             sh_busy,
    output logic             sh_done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } rot_state_t;

    rot_state_t          state;
    logic [SW-1:0]       cnt;
    logic                left_q;
    logic [2*WIDTH-1:0]  pair;
    logic [2*WIDTH-1:0]  pair_rotl;
    logic [2*WIDTH-1:0]  pair_rotr;

    assign pair_rotl = {pair[2*WIDTH-2:0], pair[2*WIDTH-1]};
    assign pair_rotr = {pair[0], pair[2*WIDTH-1:1]};

    assign m = pair[2*WIDTH-1:WIDTH];
    assign n = pair[WIDTH-1:0];

    // The top already drops pair writes while busy, so writes are only honoured outside SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            cnt     <= '0;
            left_q  <= 1'b0;
            pair    <= '0;
            sh_busy <= 1'b0;
            sh_done <= 1'b0;
        end else begin
            sh_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (wr_m) pair[2*WIDTH-1:WIDTH] <= wr_data;
                    if (wr_n) pair[WIDTH-1:0] <= wr_data;
                    if (sh_start) begin
                        left_q <= sh_left;
                        cnt    <= sh_amt;
                        if (sh_amt != '0) begin
                            state   <= StShift;
                            sh_busy <= 1'b1;
                        end else begin
                            state   <= StDone;
                            sh_done <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    pair <= left_q ? pair_rotl : pair_rotr;
                    cnt  <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        state   <= StDone;
                        sh_busy <= 1'b0;
                        sh_done <= 1'b1;
                    end
                end
                StDone: begin
                    if (wr_m) pair[2*WIDTH-1:WIDTH] <= wr_data;
                    if (wr_n) pair[WIDTH-1:0] <= wr_data;
                    state <= StIdle;
                end
                default: begin
                    state   <= StIdle;
                    sh_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// Register file with a built-in paged program counter and a {m,n} pair rotator.
// Optional REGFILE_BYPASS_EN forwards accepted same-cycle write data to the read ports.
module param_reg_file
    import instr_pack::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned PC_HI_W = 2,
    parameter logic [PC_HI_W+WIDTH-1:0] START_ADDR = '0,
    localparam int unsigned AW = $clog2(NREGS),
    localparam int unsigned SW = $clog2(2 * WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [AW-1:0]            rd_addr_a,
    input  logic [AW-1:0]            rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    input  logic [1:0]               pc_op,
    input  logic [AW-1:0]            br_sel,
    input  logic                     br_nz,
    input  logic [PC_HI_W-1:0]       ljp_page,
    input  logic                     sh_start,
    input  logic                     sh_left,
    input  logic [SW-1:0]            sh_amt,
    output logic                     sh_busy,
    output logic                     sh_done,
    output logic [PC_HI_W+WIDTH-1:0] p
);

    localparam logic [AW-1:0] ADDR_PC  = AW'(NREGS - R_PC_OFS);
    localparam logic [AW-1:0] ADDR_TGT = AW'(NREGS - R_TGT_OFS);
    localparam logic [AW-1:0] ADDR_M   = AW'(R_M);
    localparam logic [AW-1:0] ADDR_N   = AW'(R_N);

    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   view   [NREGS];
    logic [WIDTH-1:0]   pc_lo_q, pc_lo_d;
    logic [PC_HI_W-1:0] pc_hi_q, pc_hi_d;
    logic [WIDTH-1:0]   m_val, n_val;
    logic [WIDTH-1:0]   br_val, tgt_val;
    logic               br_taken;
    logic               wr_pair;
    logic               wr_ok;

    assign wr_pair = (wr_addr == ADDR_M) || (wr_addr == ADDR_N);
    assign wr_ok   = wr_en && (wr_addr != ADDR_PC) && !(sh_busy && wr_pair);

    // Architectural view of every address: PC low and the rotate pair live outside regs_q.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            view[i] = regs_q[i];
        end
        view[ADDR_PC] = pc_lo_q;
        view[ADDR_M]  = m_val;
        view[ADDR_N]  = n_val;
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_data_a = (wr_ok && (rd_addr_a == wr_addr)) ? wr_data : view[rd_addr_a];
    assign rd_data_b = (wr_ok && (rd_addr_b == wr_addr)) ? wr_data : view[rd_addr_b];
`else
    assign rd_data_a = view[rd_addr_a];
    assign rd_data_b = view[rd_addr_b];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok && !wr_pair) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Branch decisions read the pre-write view, never forwarded data.
    always_comb begin
        br_val   = view[br_sel];
        tgt_val  = view[ADDR_TGT];
        br_taken = br_nz ? (br_val != '0) : (br_val == '0);
        pc_lo_d  = pc_lo_q;
        pc_hi_d  = pc_hi_q;
        if (start) begin
            {pc_hi_d, pc_lo_d} = START_ADDR;
        end else begin
            unique case (pc_op_t'(pc_op))
                PC_SEQ:  pc_lo_d = pc_lo_q + WIDTH'(1);
                PC_BR:   pc_lo_d = br_taken ? tgt_val : pc_lo_q + WIDTH'(1);
                PC_LJMP: begin
                    pc_lo_d = tgt_val;
                    pc_hi_d = ljp_page;
                end
                PC_HOLD: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {pc_hi_q, pc_lo_q} <= START_ADDR;
        end else begin
            pc_lo_q <= pc_lo_d;
            pc_hi_q <= pc_hi_d;
        end
    end

    assign p = {pc_hi_q, pc_lo_q};

    pair_rotator #(
        .WIDTH (WIDTH)
    ) u_pair_rotator (
        .clk      (clk),
        .rst_n    (rst_n),
        .sh_start (sh_start),
        .sh_left  (sh_left),
        .sh_amt   (sh_amt),
        .wr_m     (wr_ok && (wr_addr == ADDR_M)),
        .wr_n     (wr_ok && (wr_addr == ADDR_N)),
        .wr_data  (wr_data),
        .m        (m_val),
        .n        (n_val),
        .sh_busy  (sh_busy),
        .sh_done  (sh_done)
    );

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: PC sequencing/branching, writes, forwarding and rotation.
module tb_param_reg_file;
    import instr_pack::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NREGS   = 16;
    localparam int unsigned PC_HI_W = 2;
    localparam int unsigned AW      = 4;
    localparam int unsigned SW      = 4;
    localparam logic [9:0]  START   = 10'h100;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     start = 1'b0;
    logic                     wr_en = 1'b0;
    logic [AW-1:0]            wr_addr = '0;
    logic [WIDTH-1:0]         wr_data = '0;
    logic [AW-1:0]            rd_addr_a = '0;
    logic [AW-1:0]            rd_addr_b = '0;
    logic [WIDTH-1:0]         rd_data_a, rd_data_b;
    logic [1:0]               pc_op = PC_HOLD;
    logic [AW-1:0]            br_sel = '0;
    logic                     br_nz = 1'b0;
    logic [PC_HI_W-1:0]       ljp_page = '0;
    logic                     sh_start = 1'b0;
    logic                     sh_left = 1'b0;
    logic [SW-1:0]            sh_amt = '0;
    logic                     sh_busy, sh_done;
    logic [PC_HI_W+WIDTH-1:0] p;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    param_reg_file #(
        .WIDTH      (WIDTH),
        .NREGS      (NREGS),
        .PC_HI_W    (PC_HI_W),
        .START_ADDR (START)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .pc_op     (pc_op),
        .br_sel    (br_sel),
        .br_nz     (br_nz),
        .ljp_page  (ljp_page),
        .sh_start  (sh_start),
        .sh_left   (sh_left),
        .sh_amt    (sh_amt),
        .sh_busy   (sh_busy),
        .sh_done   (sh_done),
        .p         (p)
    );

    always #5 clk = ~clk;

    task automatic push(input string name, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; pc_op = PC_HOLD;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd4;
        #1 rst_n = 1'b0;
        push("reset_p", 32'(START));
        push("reset_busy", 32'd0);
        push("reset_done", 32'd0);
        push("reset_reg3", 32'd0);
        push("reset_m", 32'd0);
        #1;
        e = sb.pop_front(); checks++;
        if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(sh_busy) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, sh_busy, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(sh_done) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, sh_done, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(rd_data_a) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_a, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(rd_data_b) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_b, e.val); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_pc_seq();
        for (int i = 1; i <= 3; i++) begin
            pc_op = PC_SEQ;
            push("seq_p", 32'(START) + 32'(i));
            tick();
            e = sb.pop_front(); checks++;
            if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        end
        pc_op = PC_HOLD;
    endtask

    task automatic test_pc_wrap();
        do_write(4'd14, 8'hFF);
        pc_op = PC_LJMP; ljp_page = 2'd1;
        push("wrap_ljmp_p", 32'h1FF);
        tick();
        e = sb.pop_front(); checks++;
        if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        pc_op = PC_SEQ;
        push("wrap_seq_p", 32'h100);
        tick();
        e = sb.pop_front(); checks++;
        if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        pc_op = PC_HOLD;
    endtask

    task automatic test_branch();
        logic [1:0]  ops  [6] = '{PC_BR, PC_BR, PC_LJMP, PC_SEQ, PC_BR, PC_BR};
        logic        nzs  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        wrs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps [6] = '{32'h140, 32'h141, 32'h240, 32'h241, 32'h240, 32'h241};
        do_write(4'd14, 8'h40);
        do_write(4'd3, 8'h00);
        br_sel = 4'd3; ljp_page = 2'd2;
        for (int i = 0; i < 6; i++) begin
            pc_op = ops[i]; br_nz = nzs[i];
            wr_en = wrs[i]; wr_addr = 4'd3; wr_data = 8'h05;
            push("branch_p", exps[i]);
            tick();
            e = sb.pop_front(); checks++;
            if (32'(p) !== e.val) begin errors++; $display("FAIL %s[%0d] got %h expected %h", e.name, i, p, e.val); end
        end
        wr_en = 1'b0; pc_op = PC_HOLD;
    endtask

    task automatic test_start_and_pc_write();
        start = 1'b1; pc_op = PC_LJMP; ljp_page = 2'd3;
        push("start_p", 32'(START));
        tick();
        e = sb.pop_front(); checks++;
        if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        start = 1'b0;
        rd_addr_a = 4'd15;
        do_write(4'd15, 8'h77);
        push("pcwr_p", 32'(START));
        push("pcwr_rd", 32'h00);
        e = sb.pop_front(); checks++;
        if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(rd_data_a) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_a, e.val); end
    endtask

    task automatic test_bypass();
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd15;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h5A; pc_op = PC_HOLD;
`ifdef REGFILE_BYPASS_EN
        push("bypass_same_cycle", 32'h5A);
`else
        push("bypass_same_cycle", 32'h00);
`endif
        #1;
        e = sb.pop_front(); checks++;
        if (32'(rd_data_a) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_a, e.val); end
        push("bypass_after", 32'h5A);
        tick();
        e = sb.pop_front(); checks++;
        if (32'(rd_data_a) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_a, e.val); end
        wr_addr = 4'd15; wr_data = 8'hEE;
        push("bypass_dropped", 32'h00);
        #1;
        e = sb.pop_front(); checks++;
        if (32'(rd_data_b) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_b, e.val); end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_rotate();
        logic [1:0] bd [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        int dones = 0;
        do_write(4'd4, 8'h81);
        do_write(4'd5, 8'h01);
        rd_addr_a = 4'd4; rd_addr_b = 4'd5;
        sh_start = 1'b1; sh_left = 1'b1; sh_amt = 4'd3;
        for (int i = 0; i < 5; i++) push("rot_busy_done", 32'(bd[i]));
        for (int i = 0; i < 5; i++) begin
            tick();
            // Conflicting start during SHIFT must be ignored; R_M write while busy must drop.
            sh_start = (i < 2); sh_left = 1'b0; sh_amt = 4'd1;
            wr_en = (i == 0); wr_addr = 4'd4; wr_data = 8'h55;
            dones += int'(sh_done);
            e = sb.pop_front(); checks++;
            if (32'({sh_busy, sh_done}) !== e.val) begin
                errors++; $display("FAIL %s[%0d] got %b expected %b", e.name, i, {sh_busy, sh_done}, e.val[1:0]);
            end
        end
        wr_en = 1'b0; sh_start = 1'b0;
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL rot_done_pulses got %0d expected 1", dones); end
        push("rot_m", 32'h08); push("rot_n", 32'h0C);
        e = sb.pop_front(); checks++;
        if (32'(rd_data_a) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_a, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(rd_data_b) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, rd_data_b, e.val); end

        sh_start = 1'b1; sh_amt = 4'd0;
        push("rot0_busy_done", 32'b01);
        tick();
        sh_start = 1'b0;
        e = sb.pop_front(); checks++;
        if (32'({sh_busy, sh_done}) !== e.val) begin errors++; $display("FAIL %s got %b expected %b", e.name, {sh_busy, sh_done}, e.val[1:0]); end
        push("rot0_pair", 32'h080C);
        e = sb.pop_front(); checks++;
        if (32'({rd_data_a, rd_data_b}) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, {rd_data_a, rd_data_b}, e.val); end
        tick();

        sh_start = 1'b1; sh_left = 1'b0; sh_amt = 4'd1;
        tick();
        sh_start = 1'b0;
        tick();
        push("rotr_done", 32'd1);
        push("rotr_pair", 32'h0406);
        e = sb.pop_front(); checks++;
        if (32'(sh_done) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, sh_done, e.val); end
        e = sb.pop_front(); checks++;
        if (32'({rd_data_a, rd_data_b}) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, {rd_data_a, rd_data_b}, e.val); end
        tick();
    endtask

    task automatic test_reset_mid_rotate();
        int dones = 0;
        do_write(4'd4, 8'h81);
        do_write(4'd5, 8'h01);
        rd_addr_a = 4'd4; rd_addr_b = 4'd5;
        sh_start = 1'b1; sh_left = 1'b1; sh_amt = 4'd5;
        tick();
        sh_start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        push("rstmid_busy_done", 32'b00);
        push("rstmid_pair", 32'h0000);
        push("rstmid_p", 32'(START));
        #1;
        e = sb.pop_front(); checks++;
        if (32'({sh_busy, sh_done}) !== e.val) begin errors++; $display("FAIL %s got %b expected %b", e.name, {sh_busy, sh_done}, e.val[1:0]); end
        e = sb.pop_front(); checks++;
        if (32'({rd_data_a, rd_data_b}) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, {rd_data_a, rd_data_b}, e.val); end
        e = sb.pop_front(); checks++;
        if (32'(p) !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, p, e.val); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            dones += int'(sh_done) + int'(sh_busy);
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL rstmid_no_activity got %0d expected 0", dones); end
        sh_start = 1'b1; sh_amt = 4'd0;
        push("rstmid_idle_start", 32'b01);
        tick();
        sh_start = 1'b0;
        e = sb.pop_front(); checks++;
        if (32'({sh_busy, sh_done}) !== e.val) begin errors++; $display("FAIL %s got %b expected %b", e.name, {sh_busy, sh_done}, e.val[1:0]); end
    endtask

    initial begin
        test_reset();
        test_pc_seq();
        test_pc_wrap();
        test_branch();
        test_start_and_pc_write();
        test_bypass();
        test_rotate();
        test_reset_mid_rotate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter WIDTH, default 8: register and PC-low width in bits, >=4.
REQ-002 Parameter NREGS, default 16: register count, power of two, >=8; AW = $clog2(NREGS).
REQ-003 Parameter PC_HI_W, default 2: PC page width in bits.
REQ-004 Parameter START_ADDR, default 0: PC load value, PC_HI_W+WIDTH bits.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  high holds PC at START_ADDR; no PC advance.
REQ-008 wr_en  in  1 / wr_addr  in  AW / wr_data  in  WIDTH  write port.
REQ-009 rd_addr_a, rd_addr_b  in  AW; rd_data_a, rd_data_b  out  WIDTH  combinational read ports.
REQ-010 pc_op  in  2  PC_SEQ / PC_BR / PC_LJMP / PC_HOLD.
REQ-011 br_sel  in  AW  register tested by PC_BR; br_nz  in  1  0 = branch if zero, 1 = branch if nonzero.
REQ-012 ljp_page  in  PC_HI_W  page loaded by PC_LJMP.
REQ-013 sh_start  in  1 / sh_left  in  1 / sh_amt  in  $clog2(2*WIDTH)  pair-rotate request.
REQ-014 sh_busy  out  1 / sh_done  out  1  rotate status; p  out  PC_HI_W+WIDTH  program counter.

Function
REQ-015 Fixed roles: R_PC = NREGS-1 (PC low), R_TGT = NREGS-2 (branch target), R_M = 4, R_N = 5 (rotate pair {m,n}, m high).
REQ-016 wr_en writes wr_data to wr_addr at posedge; writes to R_PC are dropped.
REQ-017 While sh_busy, writes to R_M or R_N are dropped; other addresses are written.
REQ-018 PC, start low: PC_SEQ: pc_lo+1 modulo 2^WIDTH, page unchanged; PC_HOLD: unchanged.
REQ-019 PC_BR: condition met -> pc_lo = reg[R_TGT]; otherwise pc_lo+1; page unchanged.
REQ-020 PC_LJMP: pc_lo = reg[R_TGT]; page = ljp_page.
REQ-021 PC decisions use register values from before any write in the same cycle.
REQ-022 start high: p = START_ADDR next posedge, regardless of pc_op.
REQ-023 Rotate FSM states IDLE, SHIFT, DONE; IDLE + sh_start with sh_amt != 0 -> SHIFT and latch amount and direction.
REQ-024 SHIFT rotates the 2*WIDTH-bit pair {m,n} one bit per cycle in the latched direction, decrements count, and goes to DONE after the last step.
REQ-025 DONE lasts one cycle with sh_done = 1, then IDLE; sh_busy = 1 in SHIFT only.
REQ-026 sh_amt = 0 goes IDLE -> DONE directly with no pair change; sh_start is ignored outside IDLE.
REQ-027 Total latency: sh_amt busy cycles, plus one sh_done cycle.

Reset
REQ-028 rst_n low: all registers 0, p = START_ADDR, FSM IDLE, sh_busy = 0, sh_done = 0, taking effect immediately.
REQ-029 Reset mid-rotate abandons the operation; no sh_done pulse is produced.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: a read address equal to an accepted same-cycle write address returns wr_data (forwarding).
REQ-031 REGFILE_BYPASS_EN undefined: reads return the stored pre-write value; dropped writes are never forwarded in either case.

Structure
REQ-032 Package instr_pack holds the pc_op enum (pc_op_t) and localparams R_M, R_N, R_TGT_OFS, R_PC_OFS.
REQ-033 Sub-module pair_rotator holds the rotate FSM, counter and pair datapath.

Verification
REQ-034 Reset with START_ADDR = 0x100, then release with start low and PC_SEQ for 3 cycles -> p = 0x100, 0x101, 0x102, 0x103.
REQ-035 pc_lo = 0xFF, page 1, PC_SEQ -> p = 0x100 (low byte wraps, page kept).
REQ-036 reg[14] = 0x40 and reg[3] = 0, with PC_BR, br_sel = 3, br_nz = 0 -> pc_lo = 0x40; with br_nz = 1 -> pc_lo+1; PC_LJMP with ljp_page = 2 -> p = 0x240.
REQ-037 m = 0x81 and n = 0x01, sh_left = 1, sh_amt = 3 -> 3 busy cycles, then m = 0x08, n = 0x0C, and a single sh_done pulse; a write to R_M during busy is dropped.
REQ-038 Write 0x5A to reg 7 with rd_addr_a = 7 in the same cycle -> rd_data_a = 0x5A with REGFILE_BYPASS_EN, and the old value without it.
REQ-039 rst_n asserted on the second rotate cycle -> pair = 0, FSM IDLE, no sh_done.
